mdu_iter_unit: RTL and testbench

- Parametrised iterative multiply/divide unit; next-generation replacement for the fixed 32-bit MDU inside the core's MDU macro.
- Executes all eight RV32M/RV64M ops selected by funct3 and returns one selected XLEN result.
- Configurable radix; div-by-zero and signed-overflow early-out; kill input for pipeline flush.
- Sits between the execute stage and writeback, using a start/busy/done/ack handshake.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_iter_unit_if.sv | 24 ++
 rtl/mdu_div_step.sv | 29 ++
 rtl/mdu_iter_unit.sv | 165 ++++++++++++++++
 tb/tb_mdu_iter_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared opcodes, FSM states and constants for the iterative MDU
package mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // Most-negative value; for XLEN=32 take the top 32 bits of the 64-bit constant
    localparam logic [31:0] MDU_MOST_NEG32 = 32'h8000_0000;
    localparam logic [63:0] MDU_MOST_NEG64 = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/mdu_iter_unit_if.sv
// rtl/mdu_iter_unit_if.sv - start/busy/done/ack request and result bundle
interface mdu_iter_unit_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            ack;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, a, b, kill, ack,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, a, b, kill, ack,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - combinational DIV_BPC-bit restoring division step
module mdu_div_step #(
    parameter int XLEN    = 32,
    parameter int DIV_BPC = 1
) (
    input  logic [XLEN-1:0]    i_rem,
    input  logic [DIV_BPC-1:0] i_bits,
    input  logic [XLEN-1:0]    i_divisor,
    output logic [XLEN-1:0]    o_rem,
    output logic [DIV_BPC-1:0] o_q
);
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_part;

    always_comb begin
        w_part  = i_rem;
        w_trial = '0;
        o_q     = '0;
        for (int k = DIV_BPC - 1; k >= 0; k--) begin
            w_trial = {w_part, i_bits[k]};
            if (w_trial >= {1'b0, i_divisor}) begin
                w_trial = w_trial - {1'b0, i_divisor};
                o_q[k]  = 1'b1;
            end
            w_part = w_trial[XLEN-1:0];
        end
        o_rem = w_part;
    end
endmodule

// File: rtl/mdu_iter_unit.sv
// rtl/mdu_iter_unit.sv - iterative RV M-extension multiply/divide unit
// MDU_DIVREM_FUSE_EN: reuse the last division's quotient/remainder for a matching DIV/REM pair
module mdu_iter_unit
    import mdu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 2,
    parameter int DIV_BPC = 1
) (
    input  logic           clk,
    input  logic           rst,
    mdu_iter_unit_if.slave bus
);
    localparam int CW    = $clog2(XLEN + 1);
    localparam int N_MUL = XLEN / MUL_BPC;
    localparam int N_DIV = XLEN / DIV_BPC;
    localparam logic [XLEN-1:0] MOST_NEG = MDU_MOST_NEG64[63 -: XLEN];

    mdu_state_e        r_state, w_state_nxt;
    logic [2:0]        r_op;
    logic              r_sa, r_sb;
    logic [2*XLEN-1:0] r_acc, r_mcand;
    logic [XLEN-1:0]   r_mplier, r_rem, r_quo, r_dvs, r_result;
    logic [CW-1:0]     r_cnt;

    logic              w_accept, w_last, w_a_sgn, w_b_sgn, w_by_zero, w_ovf, w_early;
    logic              w_fuse_hit;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_early_res, w_fuse_res;
    logic [2*XLEN-1:0] w_acc_nxt, w_prod;
    logic [XLEN-1:0]   w_rem_step, w_quo_nxt, w_q_fin, w_r_fin, w_final;
    logic [DIV_BPC-1:0] w_q_step;

    assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.kill;
    assign w_last   = (r_cnt == CW'(1));

    // Operand decode: magnitudes feed an unsigned core, signs fix the result at the end
    assign w_a_sgn = bus.a[XLEN-1] && (bus.funct3 == MDU_MULH || bus.funct3 == MDU_MULHSU ||
                                       bus.funct3 == MDU_DIV  || bus.funct3 == MDU_REM);
    assign w_b_sgn = bus.b[XLEN-1] && (bus.funct3 == MDU_MULH || bus.funct3 == MDU_DIV ||
                                       bus.funct3 == MDU_REM);
    assign w_a_mag = w_a_sgn ? -bus.a : bus.a;
    assign w_b_mag = w_b_sgn ? -bus.b : bus.b;

    assign w_by_zero = bus.funct3[2] && (bus.b == '0);
    assign w_ovf     = bus.funct3[2] && !bus.funct3[0] && (bus.a == MOST_NEG) && (bus.b == '1);
    assign w_early   = w_by_zero || w_ovf || w_fuse_hit;
    assign w_early_res = w_by_zero ? (bus.funct3[1] ? bus.a : '1) :
                         w_ovf     ? (bus.funct3[1] ? '0 : bus.a) : w_fuse_res;

    always_comb begin
        w_acc_nxt = r_acc;
        for (int i = 0; i < MUL_BPC; i++) begin
            if (r_mplier[i]) w_acc_nxt = w_acc_nxt + (r_mcand << i);
        end
    end

    mdu_div_step #(.XLEN(XLEN), .DIV_BPC(DIV_BPC)) u_div_step (
        .i_rem     (r_rem),
        .i_bits    (r_quo[XLEN-1 -: DIV_BPC]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_step),
        .o_q       (w_q_step)
    );
    assign w_quo_nxt = {r_quo[XLEN-DIV_BPC-1:0], w_q_step};

    assign w_prod  = (r_sa ^ r_sb) ? -w_acc_nxt : w_acc_nxt;
    assign w_q_fin = (r_sa ^ r_sb) ? -w_quo_nxt : w_quo_nxt;
    assign w_r_fin = r_sa ? -w_rem_step : w_rem_step;
    assign w_final = !r_op[2] ? ((r_op == MDU_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]) :
                     (r_op[1] ? w_r_fin : w_q_fin);

`ifdef MDU_DIVREM_FUSE_EN
    logic            r_fz_valid, r_fz_signed;
    logic [XLEN-1:0] r_fz_a, r_fz_b, r_fz_q, r_fz_r;

    assign w_fuse_hit = bus.funct3[2] && r_fz_valid && (bus.a == r_fz_a) && (bus.b == r_fz_b) &&
                        (r_fz_signed == !bus.funct3[0]);
    assign w_fuse_res = bus.funct3[1] ? r_fz_r : r_fz_q;

    // Entry is armed only by a division that runs to completion without kill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fz_valid  <= 1'b0;
            r_fz_signed <= 1'b0;
            r_fz_a      <= '0;
            r_fz_b      <= '0;
            r_fz_q      <= '0;
            r_fz_r      <= '0;
        end else if (w_accept && bus.funct3[2] && !w_fuse_hit) begin
            r_fz_valid  <= 1'b0;
            r_fz_signed <= !bus.funct3[0];
            r_fz_a      <= bus.a;
            r_fz_b      <= bus.b;
        end else if (r_state == ST_CALC && !bus.kill && w_last && r_op[2]) begin
            r_fz_valid  <= 1'b1;
            r_fz_q      <= w_q_fin;
            r_fz_r      <= w_r_fin;
        end
    end
`else
    assign w_fuse_hit = 1'b0;
    assign w_fuse_res = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_early ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (bus.kill)    w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: if (bus.kill || bus.ack) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op     <= bus.funct3;
            r_sa     <= w_a_sgn;
            r_sb     <= w_b_sgn;
            r_cnt    <= bus.funct3[2] ? CW'(N_DIV) : CW'(N_MUL);
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_rem    <= '0;
            r_quo    <= w_a_mag;
            r_dvs    <= w_b_mag;
            if (w_early) r_result <= w_early_res;
        end else if (r_state == ST_CALC && !bus.kill) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_op[2]) begin
                r_rem <= w_rem_step;
                r_quo <= w_quo_nxt;
            end else begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << MUL_BPC;
                r_mplier <= r_mplier >> MUL_BPC;
            end
            if (w_last) r_result <= w_final;
        end
    end

    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.result = r_result;
endmodule

// File: tb/tb_mdu_iter_unit.sv
// tb/tb_mdu_iter_unit.sv - directed and randomized bench for mdu_iter_unit against an arithmetic model
module tb_mdu_iter_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_exp = '0;

    always #5 clk = ~clk;

    mdu_iter_unit_if #(.XLEN(32)) bus ();

    mdu_iter_unit #(.XLEN(32), .MUL_BPC(2), .DIV_BPC(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef MDU_DIVREM_FUSE_EN
    bit          fz_valid = 1'b0;
    bit          fz_signed;
    logic [31:0] fz_a, fz_b;
`endif

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.a      = a;
        bus.b      = b;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.a      = $urandom;
        bus.b      = $urandom;
    endtask

    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        while (!bus.done && lat < 100) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.busy) busy_ok = 1'b0;
    endtask

    task automatic ack_it();
        bus.ack = 1'b1;
        @(posedge clk); #1;
        bus.ack = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_r;
        int exp_l, lat;
        bit busy_ok, is_div, spec, hit;
        exp_r  = ref_res(f3, a, b);
        is_div = f3[2];
        spec   = is_div && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        hit    = 1'b0;
`ifdef MDU_DIVREM_FUSE_EN
        hit = is_div && !spec && fz_valid && a == fz_a && b == fz_b && fz_signed == !f3[0];
`endif
        exp_l = (spec || hit) ? 1 : (is_div ? 33 : 17);
        issue(f3, a, b);
        wait_done(lat, busy_ok);
        check({tag, "_result"}, bus.result, exp_r);
        check({tag, "_latency"}, lat, exp_l);
        check({tag, "_busy"}, busy_ok, 1);
        ack_it();
        check({tag, "_idle"}, {bus.busy, bus.done}, 0);
`ifdef MDU_DIVREM_FUSE_EN
        if (is_div && !hit) begin
            fz_valid  = !spec;
            fz_a      = a;
            fz_b      = b;
            fz_signed = !f3[0];
        end
`endif
        last_exp = exp_r;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ra, rb, exp_r;
        logic [2:0]  rf;
        bit          saw_done;
        int          lat;
        bit          busy_ok;

        rst = 1'b1;
        bus.start = 1'b0; bus.funct3 = '0; bus.a = '0; bus.b = '0; bus.kill = 1'b0; bus.ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_check("divu_by_zero", 3'd5, 32'h0000_1234, 32'h0);
        check("divu_by_zero_value", last_exp, 32'hFFFF_FFFF);
        run_check("rem_overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_check("div_overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_check("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulhu_max_value", last_exp, 32'hFFFF_FFFE);

        // Kill in CALC: back to IDLE next cycle, result keeps the previous value
        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (4) begin @(posedge clk); #1; end
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        check("kill_busy", bus.busy, 0);
        check("kill_done", bus.done, 0);
        check("kill_result", bus.result, last_exp);
        saw_done = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (bus.done || bus.busy) saw_done = 1'b1; end
        check("kill_stays_idle", saw_done, 0);

        run_check("mul_3_m4", 3'd0, 32'd3, 32'hFFFF_FFFC);
        check("mul_3_m4_value", last_exp, 32'hFFFF_FFF4);
        run_check("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2_value", last_exp, 32'hFFFF_FFFD);
        run_check("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
        check("rem_m7_2_value", last_exp, 32'hFFFF_FFFF);

        // DONE held without ack; start in DONE ignored; start together with ack dropped
        ra = $urandom; rb = $urandom;
        exp_r = ref_res(3'd1, ra, rb);
        issue(3'd1, ra, rb);
        wait_done(lat, busy_ok);
        check("hold_latency", lat, 17);
        for (int i = 0; i < 4; i++) begin
            bus.start = (i == 2);
            bus.funct3 = 3'd0;
            @(posedge clk); #1;
            check("hold_done", bus.done, 1);
            check("hold_result", bus.result, exp_r);
        end
        bus.ack = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.ack = 1'b0;
        bus.start = 1'b0;
        check("ack_busy", bus.busy, 0);
        check("ack_done", bus.done, 0);
        @(posedge clk); #1;
        check("ack_start_dropped", bus.busy, 0);
        check("ack_result", bus.result, exp_r);

        bus.start = 1'b1; bus.kill = 1'b1; bus.funct3 = 3'd4; bus.a = 32'd9; bus.b = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.kill = 1'b0;
        check("idle_kill_start", {bus.busy, bus.done}, 0);

        run_check("fuse_div", 3'd4, 32'd100, 32'd7);
        run_check("fuse_rem", 3'd6, 32'd100, 32'd7);
        check("fuse_rem_value", last_exp, 32'd2);
        run_check("fuse_remu_other_sign", 3'd7, 32'd100, 32'd7);

        for (int n = 0; n < 40; n++) begin
            rf = 3'($urandom);
            if (n == 0 || $urandom_range(0, 3) != 0) begin
                ra = pick_operand();
                rb = pick_operand();
            end
            run_check($sformatf("rand%0d_f%0d", n, rf), rf, ra, rb);
        end

        run_check("pre_reset_mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd4, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("midreset_busy", bus.busy, 0);
        check("midreset_done", bus.done, 0);
        check("midreset_result", bus.result, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("postreset_idle", {bus.busy, bus.done}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
